// File: rtl/life_gen_sched_if.sv
// Cell-bank port bundle between the generation scheduler and the two cell banks:
// a single front-bank read port and a back-bank write port.
interface life_gen_sched_if;
  logic [12:0] rd_addr;
  logic        rd_data;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic        wr_data;

  modport master (
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/life_gen_sched.sv
// Game of Life generation scheduler: sweeps the toroidal grid one cell at a time,
// shares the front-bank read port with the display, and swaps banks on a frame tick.
module life_gen_sched #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             rdn,
  input  logic [8:0]       row_addr,
  input  logic [9:0]       col_addr,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       speed,
  life_gen_sched_if.master bank,
  output logic             bank_sel,
  output logic             pix_cell,
  output logic             busy,
  output logic [15:0]      gen_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);

  function automatic logic next_cell(input logic centre, input logic [3:0] n);
    return (n == 4'd3) || (centre && (n == 4'd2));
  endfunction

  state_t      state_r, state_s;
  logic        vs_q_r, tick_s, start_s, pend_r;
  logic [3:0]  fcnt_r, k_r, ret_k_r, cnt_r, cnt_s;
  logic [5:0]  row_r, row_up_s, row_dn_s, nb_row_s;
  logic [6:0]  col_r, col_lf_s, col_rt_s, nb_col_s;
  logic        centre_r, centre_s, eng_gnt_s, eng_gnt_r, disp_gnt_r, last_cell_s;
  logic [12:0] rd_addr_s, wr_addr_r;
  logic        wr_en_r, wr_data_r, bank_sel_r, pix_r, busy_r;
  logic [15:0] gen_cnt_r;
  logic        unused_s;

  assign tick_s      = vs_q_r & ~vs;
  assign last_cell_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
  assign eng_gnt_s   = (state_r == ST_FETCH) && rdn;
  assign unused_s    = ^{row_addr[2:0], col_addr[2:0]};

  assign bank.rd_addr = rd_addr_s;
  assign bank.wr_en   = wr_en_r;
  assign bank.wr_addr = wr_addr_r;
  assign bank.wr_data = wr_data_r;
  assign bank_sel     = bank_sel_r;
  assign pix_cell     = pix_r;
  assign busy         = busy_r;
  assign gen_cnt      = gen_cnt_r;

  // Toroidal neighbour address for read index k (raster order over the 3x3 window)
  always_comb begin
    row_up_s = (row_r == 6'd0) ? ROW_LAST : row_r - 6'd1;
    row_dn_s = (row_r == ROW_LAST) ? 6'd0 : row_r + 6'd1;
    col_lf_s = (col_r == 7'd0) ? COL_LAST : col_r - 7'd1;
    col_rt_s = (col_r == COL_LAST) ? 7'd0 : col_r + 7'd1;
    nb_row_s = row_r;
    nb_col_s = col_r;
    case (k_r)
      4'd0, 4'd1, 4'd2: nb_row_s = row_up_s;
      4'd6, 4'd7, 4'd8: nb_row_s = row_dn_s;
      default:          nb_row_s = row_r;
    endcase
    case (k_r)
      4'd0, 4'd3, 4'd6: nb_col_s = col_lf_s;
      4'd2, 4'd5, 4'd8: nb_col_s = col_rt_s;
      default:          nb_col_s = col_r;
    endcase
  end

  // Read-port arbitration: the display always wins, the engine only reads in FETCH
  always_comb begin
    rd_addr_s = 13'd0;
    if (rst) begin
      rd_addr_s = 13'd0;
    end else if (!rdn) begin
      rd_addr_s = {row_addr[8:3], col_addr[9:3]};
    end else if (state_r == ST_FETCH) begin
      rd_addr_s = {nb_row_s, nb_col_s};
    end else begin
      rd_addr_s = 13'd0;
    end
  end

  // Merge returning engine read data into centre / neighbour count
  always_comb begin
    cnt_s    = cnt_r;
    centre_s = centre_r;
    if (eng_gnt_r && (ret_k_r == 4'd4)) begin
      centre_s = bank.rd_data;
    end else if (eng_gnt_r) begin
      cnt_s = cnt_r + {3'd0, bank.rd_data};
    end else begin
      cnt_s    = cnt_r;
      centre_s = centre_r;
    end
  end

  // Sweep sequencing and trigger decision
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && ((run && (fcnt_r == speed)) || (!run && pend_r))) begin
          state_s = ST_FETCH;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (eng_gnt_s && (k_r == 4'd8)) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DRAIN: state_s = ST_WRITE;
      ST_WRITE: begin
        if (last_cell_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (tick_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control registers: state, frame counting, step request, bank swap
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      vs_q_r     <= 1'b0;
      busy_r     <= 1'b0;
      fcnt_r     <= 4'd0;
      pend_r     <= 1'b0;
      bank_sel_r <= 1'b0;
      gen_cnt_r  <= 16'd0;
    end else begin
      state_r <= state_s;
      vs_q_r  <= vs;
      busy_r  <= (state_s != ST_IDLE);
      if (tick_s && (state_r == ST_IDLE)) begin
        fcnt_r <= start_s ? 4'd0 : fcnt_r + 4'd1;
      end else if (tick_s && (state_r == ST_DONE)) begin
        fcnt_r <= 4'd0;
      end
      if (start_s || run) begin
        pend_r <= 1'b0;
      end else if (step && (state_r == ST_IDLE)) begin
        pend_r <= 1'b1;
      end
      if ((state_r == ST_DONE) && tick_s) begin
        bank_sel_r <= ~bank_sel_r;
        gen_cnt_r  <= gen_cnt_r + 16'd1;
      end
    end
  end

  // Datapath registers: read steering, neighbour accumulation, cell walk, write port
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      eng_gnt_r  <= 1'b0;
      disp_gnt_r <= 1'b0;
      ret_k_r    <= 4'd0;
      k_r        <= 4'd0;
      cnt_r      <= 4'd0;
      centre_r   <= 1'b0;
      row_r      <= 6'd0;
      col_r      <= 7'd0;
      pix_r      <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= 13'd0;
      wr_data_r  <= 1'b0;
    end else begin
      eng_gnt_r  <= eng_gnt_s;
      disp_gnt_r <= ~rdn;
      ret_k_r    <= k_r;
      wr_en_r    <= (state_r == ST_DRAIN);
      if (disp_gnt_r) begin
        pix_r <= bank.rd_data;
      end
      if (eng_gnt_s) begin
        k_r <= (k_r == 4'd8) ? 4'd0 : k_r + 4'd1;
      end
      // The last neighbour returns during DRAIN, so the write value uses the merged count
      if (state_r == ST_DRAIN) begin
        wr_addr_r <= {row_r, col_r};
        wr_data_r <= next_cell(centre_s, cnt_s);
        cnt_r     <= 4'd0;
        centre_r  <= 1'b0;
      end else begin
        cnt_r    <= cnt_s;
        centre_r <= centre_s;
      end
      if ((state_r == ST_WRITE) && (col_r == COL_LAST)) begin
        col_r <= 7'd0;
        row_r <= (row_r == ROW_LAST) ? 6'd0 : row_r + 6'd1;
      end else if (state_r == ST_WRITE) begin
        col_r <= col_r + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_life_gen_sched.sv
// Self-checking bench for life_gen_sched on a reduced 12x12 torus, with a two-bank
// memory model and a whole-grid Life reference.
module tb_life_gen_sched;
  localparam int COLS  = 12;
  localparam int ROWS  = 12;
  localparam int NCELL = COLS * ROWS;

  logic        vga_clk = 1'b0;
  logic        rst, vs, rdn, run, step;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [3:0]  speed;
  logic        bank_sel, pix_cell, busy;
  logic [15:0] gen_cnt;

  life_gen_sched_if bus();

  life_gen_sched #(.COLS(COLS), .ROWS(ROWS)) dut (
    .vga_clk  (vga_clk),
    .rst      (rst),
    .vs       (vs),
    .rdn      (rdn),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .run      (run),
    .step     (step),
    .speed    (speed),
    .bank     (bus),
    .bank_sel (bank_sel),
    .pix_cell (pix_cell),
    .busy     (busy),
    .gen_cnt  (gen_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  logic mem [0:1][0:8191];
  bit   stage_g [0:ROWS-1][0:COLS-1];
  bit   ref_cur [0:ROWS-1][0:COLS-1];
  bit   ref_nxt [0:ROWS-1][0:COLS-1];
  logic ld_req = 1'b0;
  logic ld_bank = 1'b0;
  int   wr_cnt = 0;
  int   wbase = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [12:0] addr_of(input int r, input int c);
    return {6'(r), 7'(c)};
  endfunction

  // Two-bank cell memory: registered read of the front bank, writes into the back bank
  always @(posedge vga_clk) begin
    bus.rd_data <= mem[bank_sel][bus.rd_addr];
    if (bus.wr_en) begin
      mem[~bank_sel][bus.wr_addr] <= bus.wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (ld_req) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem[ld_bank][addr_of(r, c)] <= stage_g[r][c];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic tick();
    @(negedge vga_clk); vs = 1'b0;
    @(negedge vga_clk); vs = 1'b1;
  endtask

  task automatic pulse_step();
    @(negedge vga_clk); step = 1'b1;
    @(negedge vga_clk); step = 1'b0;
  endtask

  task automatic load_grid(input bit b);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        stage_g[r][c] = ref_cur[r][c];
    @(negedge vga_clk); ld_req = 1'b1; ld_bank = b;
    @(negedge vga_clk); ld_req = 1'b0;
  endtask

  task automatic clear_ref();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        ref_cur[r][c] = 1'b0;
  endtask

  task automatic random_ref(input int pct);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        ref_cur[r][c] = ($urandom_range(0, 99) < pct);
  endtask

  // Conway's rule on a torus, straight from the definition
  task automatic compute_next();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(ref_cur[(r + dr + ROWS) % ROWS][(c + dc + COLS) % COLS]);
        ref_nxt[r][c] = (n == 3) || (ref_cur[r][c] && n == 2);
      end
  endtask

  task automatic check_back(input string tag, input bit b);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        chk($sformatf("%s(%0d,%0d)", tag, r, c), 32'(mem[b][addr_of(r, c)]), 32'(ref_nxt[r][c]));
  endtask

  task automatic wait_writes(input string tag);
    int n = 0;
    while ((wr_cnt - wbase) < NCELL && n < 20000) begin
      @(negedge vga_clk);
      n++;
    end
    cyc(20);
    chk(tag, 32'(wr_cnt - wbase), 32'(NCELL));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bank_sel"}, 32'(bank_sel), 32'd0);
    chk({tag, "_gen_cnt"},  32'(gen_cnt), 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd0);
    chk({tag, "_wr_en"},    32'(bus.wr_en), 32'd0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"},  32'(bus.wr_data), 32'd0);
    chk({tag, "_pix_cell"}, 32'(pix_cell), 32'd0);
    chk({tag, "_rd_addr"},  32'(bus.rd_addr), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge vga_clk); rst = 1'b1;
    cyc(2);
  endtask

  initial begin
    logic       pv0, pv1, pe0, pe1;
    rst = 1'b1; vs = 1'b1; rdn = 1'b1; run = 1'b0; step = 1'b0; speed = 4'd0;
    row_addr = 9'd0; col_addr = 10'd0;
    cyc(3);
    chk_reset("por");
    rst = 1'b0;
    cyc(2);

    // Reset in the middle of a sweep
    random_ref(40);
    load_grid(1'b0);
    pulse_step();
    tick();
    cyc(300);
    chk("mid_busy", 32'(busy), 32'd1);
    do_reset();
    chk_reset("midrst");
    rst = 1'b0;
    wbase = wr_cnt;
    cyc(200);
    chk("midrst_no_wr", 32'(wr_cnt - wbase), 32'd0);

    // Blinker
    clear_ref();
    ref_cur[10][9] = 1'b1; ref_cur[10][10] = 1'b1; ref_cur[10][11] = 1'b1;
    load_grid(1'b0);
    compute_next();
    wbase = wr_cnt;
    pulse_step();
    tick();
    wait_writes("blink_writes");
    chk("blink_busy_done", 32'(busy), 32'd1);
    chk("blink_gen_pre", 32'(gen_cnt), 32'd0);
    tick();
    cyc(2);
    chk("blink_bank_sel", 32'(bank_sel), 32'd1);
    chk("blink_gen_cnt", 32'(gen_cnt), 32'd1);
    chk("blink_busy", 32'(busy), 32'd0);
    chk("blink_9_10", 32'(mem[1][addr_of(9, 10)]), 32'd1);
    chk("blink_11_10", 32'(mem[1][addr_of(11, 10)]), 32'd1);
    chk("blink_10_9", 32'(mem[1][addr_of(10, 9)]), 32'd0);
    check_back("blink", 1'b1);

    // Wrap-straddling glider plus noise, with 50% display contention
    clear_ref();
    ref_cur[(0 + ROWS - 1) % ROWS][(1 + COLS - 1) % COLS] = 1'b1;
    ref_cur[(1 + ROWS - 1) % ROWS][(2 + COLS - 1) % COLS] = 1'b1;
    ref_cur[(2 + ROWS - 1) % ROWS][(0 + COLS - 1) % COLS] = 1'b1;
    ref_cur[(2 + ROWS - 1) % ROWS][(1 + COLS - 1) % COLS] = 1'b1;
    ref_cur[(2 + ROWS - 1) % ROWS][(2 + COLS - 1) % COLS] = 1'b1;
    for (int r = 4; r < 8; r++)
      for (int c = 3; c < 9; c++)
        ref_cur[r][c] = ($urandom_range(0, 3) == 0);
    load_grid(1'b1);
    compute_next();
    wbase = wr_cnt;
    pulse_step();
    tick();
    pv0 = 1'b0; pv1 = 1'b0; pe0 = 1'b0; pe1 = 1'b0;
    for (int n = 0; n < 20000 && ((wr_cnt - wbase) < NCELL || pv0 || pv1); n++) begin
      @(negedge vga_clk);
      if (pv1) chk("pix_cell", 32'(pix_cell), 32'(pe1));
      pv1 = pv0; pe1 = pe0;
      row_addr = 9'($urandom_range(0, ROWS * 8 - 1));
      col_addr = 10'($urandom_range(0, COLS * 8 - 1));
      rdn = ((wr_cnt - wbase) < NCELL) ? 1'($urandom_range(0, 1)) : 1'b1;
      pv0 = !rdn;
      pe0 = ref_cur[int'(row_addr) / 8][int'(col_addr) / 8];
    end
    rdn = 1'b1;
    wait_writes("wrap_writes");
    tick();
    cyc(2);
    chk("wrap_bank_sel", 32'(bank_sel), 32'd0);
    chk("wrap_gen_cnt", 32'(gen_cnt), 32'd2);
    chk("wrap_0_last", 32'(mem[0][addr_of(0, COLS - 1)]), 32'(ref_nxt[0][COLS - 1]));
    chk("wrap_last_0", 32'(mem[0][addr_of(ROWS - 1, 0)]), 32'(ref_nxt[ROWS - 1][0]));
    check_back("wrap", 1'b0);

    // Step while busy and step while run=1 are ignored
    random_ref(35);
    load_grid(1'b0);
    compute_next();
    wbase = wr_cnt;
    pulse_step();
    tick();
    cyc(100);
    pulse_step();
    wait_writes("ign_writes");
    tick();
    cyc(2);
    chk("ign_gen_cnt", 32'(gen_cnt), 32'd3);
    chk("ign_bank_sel", 32'(bank_sel), 32'd1);
    check_back("ign", 1'b1);
    tick();
    cyc(5);
    chk("step_busy_ignored", 32'(busy), 32'd0);
    @(negedge vga_clk); run = 1'b1; speed = 4'd15;
    pulse_step();
    @(negedge vga_clk); run = 1'b0;
    tick();
    cyc(5);
    chk("step_run_ignored", 32'(busy), 32'd0);
    chk("step_run_gen", 32'(gen_cnt), 32'd3);

    // Free-running rate: run=1, speed=3 -> one generation per 5 ticks
    do_reset();
    rst = 1'b0;
    random_ref(30);
    load_grid(1'b0);
    compute_next();
    @(negedge vga_clk); run = 1'b1; speed = 4'd3;
    for (int i = 1; i <= 10; i++) begin
      tick();
      cyc(1800);
      chk($sformatf("rate_gen_t%0d", i), 32'(gen_cnt), 32'(i / 5));
      chk($sformatf("rate_busy_t%0d", i), 32'(busy), 32'((i % 5) == 4));
      if (i == 5) check_back("rate", 1'b1);
    end
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
